// File: rtl/store_unit_if.sv
// Store request and memory write channels of the store unit.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid && ready are both high. The producer holds valid and its
// payload stable until that edge; ready may be high without valid. The store
// channel's ready depends only on buffer fullness, never on st_valid.
interface store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    // Core -> store unit request channel
    logic                  st_valid;
    logic                  st_ready;
    logic [2:0]            st_funct3;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [31:0]           st_data;

    // Store unit -> data memory write channel
    logic                  mem_wvalid;
    logic                  mem_wready;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;

    // View taken by the store unit itself
    modport slave (
        input  st_valid, st_funct3, st_addr, st_data, mem_wready,
        output st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb
    );

    // View taken by the surrounding core/memory environment
    modport master (
        output st_valid, st_funct3, st_addr, st_data, mem_wready,
        input  st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_unit.sv
// Buffered store path: formats SB/SH/SW into byte lanes plus strobe, rejects
// illegal or misaligned requests with a one-cycle error pulse, and drains
// entries in order to the data memory write port through a small FIFO.
module store_unit #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    store_unit_if.slave             bus,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    output logic                    ld_hazard,
    output logic                    err_misaligned,
    output logic                    err_illegal,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Only the word part of an address takes part in hazard matching
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // Buffer storage; r_vld marks occupied slots for the hazard search
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [31:0]           r_data [DEPTH];
    logic [3:0]            r_strb [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_err_mis;
    logic                  r_err_ill;

    logic                  w_full;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_illegal;
    logic                  w_misaligned;
    logic [1:0]            w_off;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wstrb;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic                  w_hazard;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_accept    = bus.st_valid && !w_full;
    // Bad requests complete the handshake but never occupy a slot
    assign w_push      = w_accept && !w_illegal && !w_misaligned;
    assign w_pop       = (r_count != '0) && bus.mem_wready;
    assign w_off       = bus.st_addr[1:0];
    assign w_word_addr = bus.st_addr & WORD_MASK;

    // Decode funct3 into lane-replicated data, strobe and error conditions
    always_comb begin
        w_wdata      = bus.st_data;
        w_wstrb      = 4'b1111;
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        case (bus.st_funct3)
            3'b000: begin
                w_wdata = {4{bus.st_data[7:0]}};
                w_wstrb = 4'b0001 << w_off;
            end
            3'b001: begin
                w_wdata      = {2{bus.st_data[15:0]}};
                w_wstrb      = w_off[1] ? 4'b1100 : 4'b0011;
                w_misaligned = w_off[0];
            end
            3'b010: begin
                w_misaligned = (w_off != 2'b00);
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // FIFO storage and pointers; reset drops every buffered entry at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_strb[i] <= '0;
            end
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
                r_addr[r_wr_ptr] <= w_word_addr;
                r_data[r_wr_ptr] <= w_wdata;
                r_strb[r_wr_ptr] <= w_wstrb;
                r_vld[r_wr_ptr]  <= 1'b1;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle error pulses; illegal funct3 takes priority over misalignment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_mis <= 1'b0;
            r_err_ill <= 1'b0;
        end else begin
            r_err_ill <= w_accept && w_illegal;
            r_err_mis <= w_accept && !w_illegal && w_misaligned;
        end
    end

    // Word-granular match of the pending load against every occupied slot
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (((r_addr[i] ^ ld_addr) & WORD_MASK) == '0)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign bus.st_ready   = !w_full;
    assign bus.mem_wvalid = (r_count != '0);
    assign bus.mem_waddr  = r_addr[r_rd_ptr];
    assign bus.mem_wdata  = r_data[r_rd_ptr];
    assign bus.mem_wstrb  = r_strb[r_rd_ptr];
    assign ld_hazard      = w_hazard;
    assign err_misaligned = r_err_mis;
    assign err_illegal    = r_err_ill;
    assign empty          = (r_count == '0);
    assign count          = r_count;
endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: expected memory writes are queued when a
// store is issued and a monitor pops/compares each write the DUT performs.
module tb_store_unit;
    localparam int AW    = 32;
    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_unit_if #(.ADDR_WIDTH(AW)) bus ();

    logic [AW-1:0] ld_addr;
    logic          ld_hazard;
    logic          err_misaligned;
    logic          err_illegal;
    logic          empty;
    logic [1:0]    count;

    store_unit #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .ld_addr        (ld_addr),
        .ld_hazard      (ld_hazard),
        .err_misaligned (err_misaligned),
        .err_illegal    (err_illegal),
        .empty          (empty),
        .count          (count)
    );

    // ---------------- scoreboard ----------------
    logic [67:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a write is taken on the edge after a negedge where valid&ready
    always @(negedge clk) begin
        if (reset && bus.mem_wvalid && bus.mem_wready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h strb 0x%0h, expected none",
                         bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb);
            end else begin
                check("mem_write", {bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                        input bit legal, input logic [31:0] e_addr, input logic [31:0] e_data,
                        input logic [3:0] e_strb);
        int n;
        bus.st_valid  = 1'b1;
        bus.st_funct3 = f3;
        bus.st_addr   = addr;
        bus.st_data   = data;
        n = 0;
        @(negedge clk);
        while (!bus.st_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.st_ready) check("st_ready_timeout", 68'(bus.st_ready), 68'(1));
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
        if (legal) exp_q.push_back({e_addr, e_data, e_strb});
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!empty && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 68'(empty), 68'(1));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.st_valid   = 1'b0;
        bus.st_funct3  = 3'b000;
        bus.st_addr    = '0;
        bus.st_data    = '0;
        bus.mem_wready = 1'b0;
        ld_addr        = '0;

        // Reset state
        #1;
        check("rst_empty",    68'(empty),          68'(1));
        check("rst_st_ready", 68'(bus.st_ready),   68'(1));
        check("rst_wvalid",   68'(bus.mem_wvalid), 68'(0));
        check("rst_count",    68'(count),          68'(0));
        check("rst_err",      68'({err_misaligned, err_illegal, ld_hazard}), 68'(0));
        check("rst_head",     {bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb}, 68'(0));
        step();
        step();
        reset          = 1'b1;
        bus.mem_wready = 1'b1;
        step();

        // SB to 0x103: single byte in the top lane, drains next cycle
        send(3'b000, 32'h0000_0103, 32'h1234_56AB, 1, 32'h100, 32'hABAB_ABAB, 4'b1000);
        @(negedge clk);
        check("sb_wvalid", 68'(bus.mem_wvalid), 68'(1));
        check("sb_head", {bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb},
              {32'h100, 32'hABAB_ABAB, 4'b1000});
        @(negedge clk);
        check("sb_empty_after", 68'(empty), 68'(1));
        step();

        // SH + SW under backpressure: fills buffer, head holds stable
        bus.mem_wready = 1'b0;
        send(3'b001, 32'h202, 32'hDEAD_BEEF, 1, 32'h200, 32'hBEEF_BEEF, 4'b1100);
        send(3'b010, 32'h204, 32'hCAFE_F00D, 1, 32'h204, 32'hCAFE_F00D, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_head", {bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb},
                  {32'h200, 32'hBEEF_BEEF, 4'b1100});
        end
        check("stall_count",    68'(count),        68'(2));
        check("stall_st_ready", 68'(bus.st_ready), 68'(0));
        step();
        bus.mem_wready = 1'b1;
        wait_empty("drain_in_order");

        // Misaligned and illegal requests: nothing enqueued, error pulses
        send(3'b010, 32'h101, 32'h1111_1111, 0, '0, '0, '0);
        check("sw_mis_pulse", 68'({err_misaligned, err_illegal}), 68'(2'b10));
        send(3'b001, 32'h103, 32'h2222_2222, 0, '0, '0, '0);
        check("sh_mis_pulse", 68'({err_misaligned, err_illegal}), 68'(2'b10));
        check("mis_count",    68'(count), 68'(0));
        step();
        check("mis_pulse_end", 68'({err_misaligned, err_illegal}), 68'(0));
        send(3'b100, 32'h100, 32'h3333_3333, 0, '0, '0, '0);
        check("ill_pulse", 68'({err_misaligned, err_illegal}), 68'(2'b01));
        send(3'b011, 32'h101, 32'h4444_4444, 0, '0, '0, '0);
        check("ill_mis_pulse", 68'({err_misaligned, err_illegal}), 68'(2'b01));
        step();
        check("ill_pulse_end", 68'({err_misaligned, err_illegal}), 68'(0));
        check("ill_empty",     68'(empty), 68'(1));

        // Load hazard against a buffered SB
        bus.mem_wready = 1'b0;
        send(3'b000, 32'h300, 32'h0000_0055, 1, 32'h300, 32'h5555_5555, 4'b0001);
        ld_addr = 32'h303;
        @(negedge clk);
        check("haz_same_word", 68'(ld_hazard), 68'(1));
        ld_addr = 32'h304;
        #1;
        check("haz_next_word", 68'(ld_hazard), 68'(0));
        ld_addr = 32'h303;
        step();
        bus.mem_wready = 1'b1;
        @(negedge clk);
        check("haz_while_pop", 68'(ld_hazard), 68'(1));
        step();
        check("haz_after_pop", 68'(ld_hazard), 68'(0));
        check("haz_empty",     68'(empty),     68'(1));

        // Full buffer: pop and held store in the same cycle -> no push
        bus.mem_wready = 1'b0;
        send(3'b010, 32'h400, 32'h1111_1111, 1, 32'h400, 32'h1111_1111, 4'b1111);
        send(3'b010, 32'h404, 32'h2222_2222, 1, 32'h404, 32'h2222_2222, 4'b1111);
        check("full_count", 68'(count), 68'(2));
        bus.st_valid   = 1'b1;
        bus.st_funct3  = 3'b010;
        bus.st_addr    = 32'h408;
        bus.st_data    = 32'h3333_3333;
        bus.mem_wready = 1'b1;
        step();
        check("full_pop_no_push", 68'(count),        68'(1));
        check("full_ready_back",  68'(bus.st_ready), 68'(1));
        bus.mem_wready = 1'b0;
        step();
        exp_q.push_back({32'h408, 32'h3333_3333, 4'b1111});
        bus.st_valid = 1'b0;
        check("full_third_accepted", 68'(count), 68'(2));
        bus.mem_wready = 1'b1;
        wait_empty("full_drain");

        // Reset mid-operation flushes buffered entries
        bus.mem_wready = 1'b0;
        send(3'b010, 32'h500, 32'hAAAA_5555, 1, 32'h500, 32'hAAAA_5555, 4'b1111);
        send(3'b010, 32'h504, 32'h5555_AAAA, 1, 32'h504, 32'h5555_AAAA, 4'b1111);
        #2;
        reset = 1'b0;
        #1;
        check("flush_wvalid", 68'(bus.mem_wvalid), 68'(0));
        check("flush_count",  68'(count),          68'(0));
        exp_q.delete();
        step();
        reset          = 1'b1;
        bus.mem_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_write", 68'(bus.mem_wvalid), 68'(0));
        end
        step();
        send(3'b010, 32'h0, 32'h600D_F00D, 1, 32'h0, 32'h600D_F00D, 4'b1111);
        @(negedge clk);
        check("post_reset_wvalid", 68'(bus.mem_wvalid), 68'(1));
        wait_empty("post_reset_drain");

        check("queue_drained", 68'(exp_q.size()), 68'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/store_unit.md
# store_unit

Buffered store path for the RISC-V core: accepts SB/SH/SW requests from the execute stage, checks alignment, replicates store data into byte lanes with a 4-bit byte strobe, and drains entries to the data memory write port over a valid/ready handshake. It is the write-side counterpart of the LBU/LHU/LW load path. A small in-order FIFO decouples core issue from memory backpressure. A load-hazard output lets the load path stall while a matching word is still buffered.

## Interface
- DEPTH, 2, store buffer entries; power of two, ≥2
- ADDR_WIDTH, 32, byte address width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- st_valid  in  1  core presents a store
- st_ready  out  1  unit can accept; equals !full
- st_funct3  in  3  000 SB, 001 SH, 010 SW; others illegal
- st_addr  in  ADDR_WIDTH  byte address
- st_data  in  32  rs2 value, LSB-aligned
- mem_wvalid  out  1  buffered write available
- mem_wready  in  1  memory accepts write
- mem_waddr  out  ADDR_WIDTH  word address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated data
- mem_wstrb  out  4  byte enables
- ld_addr  in  ADDR_WIDTH  address of the load currently in decode/execute
- ld_hazard  out  1  some buffered entry has the same word as ld_addr
- err_misaligned  out  1  one-cycle pulse: rejected misaligned store
- err_illegal  out  1  one-cycle pulse: rejected illegal funct3
- empty  out  1  buffer empty (used for FENCE drain)
- count  out  $clog2(DEPTH)+1  entries held

## Operation
- Accept: st_valid && st_ready. Requests that are legal and aligned enqueue one entry: word address, data, and strb.
- Lane formatting (off = st_addr[1:0]):
  - SB: wdata = {4{st_data[7:0]}}, wstrb = 4'b0001 << off.
  - SH: wdata = {2{st_data[15:0]}}, wstrb = off[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = st_data, wstrb = 4'b1111.
- Misaligned: SH with off[0]=1, or SW with off≠0. The handshake completes (st_ready unaffected) but nothing is enqueued. err_misaligned = 1 in the next cycle only.
- Illegal funct3 is handled the same way, with err_illegal. If a request is both illegal and misaligned, only err_illegal pulses.
- Drain:
  - Head entry drives mem_waddr/mem_wdata/mem_wstrb, with mem_wvalid = !empty.
  - Pop on mem_wvalid && mem_wready.
  - Outputs hold stable while mem_wvalid && !mem_wready.
- Writes leave strictly in acceptance order. There is no merging.
- ld_hazard (combinational): OR over all valid entries of entry.addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]. An entry being popped this cycle still counts.
- Pointers wrap modulo DEPTH. count is in 0..DEPTH.

## Timing
- Reset (reset=0, async): pointers and count go to 0, empty=1, st_ready=1, mem_wvalid=0, err_*=0, ld_hazard=0. mem_waddr/wdata/wstrb are 0.
- Reset asserted mid-operation discards all buffered entries immediately, with no memory write. A write in the same cycle as reset assertion is not guaranteed.
- Latency: a store accepted at edge N appears on mem_wvalid after edge N (registered). The earliest memory write is edge N+1.
- st_ready depends only on full. When full, no push occurs even if a pop happens in the same cycle; st_ready rises the cycle after the pop.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Empty push: mem_wvalid rises next cycle. There is no bypass.
- Error pulses are registered and last exactly one cycle per offending request. Back-to-back bad requests give a pulse on consecutive cycles.
- Throughput: one store per cycle while mem_wready=1 steadily.

## Test plan
- SB to 0x0000_0103 with data 0x1234_56AB, mem_wready=1 → one cycle later mem_waddr=0x100, wdata=0xABABABAB, wstrb=4'b1000; next cycle empty=1.
- SH to 0x202 with 0xDEAD_BEEF, then SW to 0x204 with 0xCAFE_F00D, mem_wready=0 for 5 cycles → count=2, st_ready=0, head stable (0x200, 0xBEEFBEEF, 4'b1100). Release → writes leave in order, 0x200 then 0x204.
- SW to 0x101 and SH to 0x103 → nothing enqueued, err_misaligned high for one cycle each, count stays 0. funct3=3'b100 → err_illegal pulse only.
- Buffer holds SB to 0x300 with mem_wready=0, ld_addr=0x303 → ld_hazard=1. With ld_addr=0x304 → ld_hazard=0. After the pop, ld_hazard=0.
- Full buffer (DEPTH=2) with st_valid held and a pop in the same cycle → no enqueue that cycle; the third store is accepted the next cycle and count returns to 2.
- Two entries buffered, reset pulsed low mid-cycle → mem_wvalid=0 and count=0 immediately. After release, no stale write appears and a fresh SW to 0x0 drains normally.
